// File: rtl/multi_key_tone_gen.sv
// Multi-key buzzer tone generator: synchronised and debounced keys select a half-period
// from a writable table, and a divider FSM produces a square wave at that pitch.
module multi_key_tone_gen #(
  parameter int NUM_KEYS        = 8,
  parameter int DIV_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        clk_50MHz,
  input  logic                        reset_button,
  input  logic [NUM_KEYS-1:0]         keys,
  input  logic                        oct_up,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_KEYS)-1:0] cfg_addr,
  input  logic [DIV_W-1:0]            cfg_data,
  output logic                        bz_out,
  output logic                        active,
  output logic [$clog2(NUM_KEYS)-1:0] key_idx
);

  localparam int AW = $clog2(NUM_KEYS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  logic [NUM_KEYS-1:0] key_sync_p0, key_sync_p1, key_db;
  logic [CW-1:0]       db_cnt [NUM_KEYS];
  logic                sel_any, sel_valid;
  logic [AW-1:0]       sel_low;
  logic [DIV_W-1:0]    tbl [NUM_KEYS];
  logic [DIV_W-1:0]    t_cur, h_next, h_reg, cnt;
  logic                t_nz, run_hold, toggle;
  logic [AW-1:0]       cur_key;
  state_t              state, state_nx;

  // Octave-up halves the half-period but never lets it collapse to zero.
  function automatic logic [DIV_W-1:0] half_period(input logic [DIV_W-1:0] t, input logic oct);
    logic [DIV_W-1:0] s;
    s = t >> 1;
    if (!oct)      return t;
    if (s == '0)   return DIV_W'(1);
    return s;
  endfunction

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      key_sync_p0 <= '0;
      key_sync_p1 <= '0;
    end else begin
      key_sync_p0 <= keys;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Debounce: count consecutive samples that disagree with the debounced level
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      key_db <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sync_p1[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_db[i] <= key_sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_any = |key_db;
    sel_low = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_db[i]) sel_low = AW'(i);
    end
  end

  // Registered selection: lowest pressed key wins, index held when all released
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      sel_valid <= 1'b0;
      key_idx   <= '0;
    end else begin
      sel_valid <= sel_any;
      if (sel_any) key_idx <= sel_low;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      for (int i = 0; i < NUM_KEYS; i++) tbl[i] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < NUM_KEYS)) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  assign t_cur  = tbl[key_idx];
  assign t_nz   = (t_cur != '0);
  assign h_next = half_period(t_cur, oct_up);

  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) state <= IDLE;
    else              state <= state_nx;
  end

  // LOAD falls back to IDLE rather than entering RUN with a zero half-period.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_valid && t_nz) state_nx = LOAD;
      LOAD:    state_nx = (sel_valid && t_nz) ? RUN : IDLE;
      RUN: begin
        if (!sel_valid || !t_nz)    state_nx = IDLE;
        else if (key_idx != cur_key) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    active   = (state == LOAD) || (state == RUN);
    run_hold = (state == RUN) && (state_nx == RUN);
    toggle   = run_hold && (cnt == h_reg - DIV_W'(1));
  end

  // Divider and buzzer flop; leaving RUN forces the output low on the next edge
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      cnt    <= '0;
      bz_out <= 1'b0;
    end else if (run_hold) begin
      if (toggle) begin
        bz_out <= ~bz_out;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end else begin
      cnt    <= '0;
      bz_out <= 1'b0;
    end
  end

  // Pitch is only sampled at LOAD and at toggle boundaries
  always_ff @(posedge clk_50MHz) begin
    if ((state == LOAD) || toggle) h_reg <= h_next;
    if (state == LOAD)             cur_key <= key_idx;
  end

endmodule

// File: tb/tb_multi_key_tone_gen.sv
// Directed bench for multi_key_tone_gen with small parameters (4 keys, 8-bit divider, 4-sample debounce).
module tb_multi_key_tone_gen;

  logic       clk_50MHz = 1'b0;
  logic       reset_button;
  logic [3:0] keys;
  logic       oct_up;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       bz_out;
  logic       active;
  logic [1:0] key_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int hi, lo, seen;

  multi_key_tone_gen #(
    .NUM_KEYS(4),
    .DIV_W(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset_button(reset_button),
    .keys(keys),
    .oct_up(oct_up),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .bz_out(bz_out),
    .active(active),
    .key_idx(key_idx)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[1:0];
    cfg_data = d[7:0];
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_active(input string tag, input logic lvl);
    for (int i = 0; i < 100 && active !== lvl; i++) step();
    chk(tag, int'(active), int'(lvl));
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    int   ok;
    prev = bz_out;
    ok   = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      step();
      if (prev === 1'b0 && bz_out === 1'b1) ok = 1;
      prev = bz_out;
    end
    chk(tag, ok, 1);
  endtask

  task automatic count_run(output int n);
    logic v;
    v = bz_out;
    n = 0;
    while (bz_out === v && n < 200) begin
      n++;
      step();
    end
  endtask

  initial begin
    reset_button = 1'b1;
    keys         = 4'b0000;
    oct_up       = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = 2'd0;
    cfg_data     = 8'd0;
    repeat (3) step();
    chk("rst_bz", int'(bz_out), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_key_idx", int'(key_idx), 0);
    reset_button = 1'b0;
    step();

    // single key, half-period 3
    cfg_write(1, 3);
    keys = 4'b0010;
    wait_active("t1_active", 1'b1);
    chk("t1_key_idx", int'(key_idx), 1);
    wait_rise("t1_rise");
    count_run(hi);
    count_run(lo);
    chk("t1_high", hi, 3);
    chk("t1_low", lo, 3);

    // two keys: lowest wins, then release it and switch to key 2
    cfg_write(2, 5);
    keys = 4'b0110;
    repeat (12) step();
    chk("t2_key_idx", int'(key_idx), 1);
    wait_rise("t2_rise_k1");
    count_run(hi);
    count_run(lo);
    chk("t2_high_k1", hi, 3);
    chk("t2_low_k1", lo, 3);
    keys = 4'b0100;
    for (int i = 0; i < 50 && key_idx !== 2'd2; i++) step();
    chk("t2_switch", int'(key_idx), 2);
    step();
    chk("t2_load_bz", int'(bz_out), 0);
    chk("t2_load_active", int'(active), 1);
    wait_rise("t2_rise_k2");
    count_run(hi);
    count_run(lo);
    chk("t2_high_k2", hi, 5);
    chk("t2_low_k2", lo, 5);

    // bouncing key never passes the debouncer
    keys = 4'b0000;
    wait_active("t3_idle", 1'b0);
    repeat (8) step();
    seen = 0;
    repeat (6) begin
      keys = 4'b0010;
      repeat (3) begin
        step();
        if (bz_out === 1'b1 || active === 1'b1) seen = 1;
      end
      keys = 4'b0000;
      step();
      if (bz_out === 1'b1 || active === 1'b1) seen = 1;
    end
    chk("t3_bounce", seen, 0);
    repeat (10) step();

    // octave-up mid half-period takes effect at the next boundary
    cfg_write(0, 6);
    keys = 4'b0001;
    wait_active("t4_active", 1'b1);
    wait_rise("t4_rise");
    step();
    step();
    oct_up = 1'b1;
    count_run(hi);
    chk("t4_rest_high", hi, 4);
    count_run(lo);
    chk("t4_oct_low", lo, 3);
    count_run(hi);
    chk("t4_oct_high", hi, 3);
    oct_up = 1'b0;
    keys   = 4'b0000;
    wait_active("t4_idle", 1'b0);
    repeat (8) step();

    // zeroing the entry silences at once; half-period 1 toggles every cycle
    cfg_write(3, 4);
    keys = 4'b1000;
    wait_active("t5_active", 1'b1);
    chk("t5_key_idx", int'(key_idx), 3);
    wait_rise("t5_rise");
    cfg_write(3, 0);
    step();
    chk("t5_zero_active", int'(active), 0);
    chk("t5_zero_bz", int'(bz_out), 0);
    cfg_write(3, 1);
    wait_rise("t5_fast_rise");
    count_run(hi);
    count_run(lo);
    chk("t5_fast_high", hi, 1);
    chk("t5_fast_low", lo, 1);

    // asynchronous reset mid-note clears the table
    for (int i = 0; i < 10 && bz_out !== 1'b1; i++) step();
    chk("t6_pre_bz", int'(bz_out), 1);
    #2 reset_button = 1'b1;
    #1;
    chk("t6_async_bz", int'(bz_out), 0);
    chk("t6_async_active", int'(active), 0);
    repeat (3) step();
    reset_button = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (bz_out !== 1'b0 || active !== 1'b0) seen = 1;
    end
    chk("t6_silent", seen, 0);
    chk("t6_key_idx", int'(key_idx), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_key_tone_gen.md
MULTI_KEY_TONE_GEN -- requirements
Module: multi_key_tone_gen

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 8: number of key inputs and half-period table entries.
REQ-002 SHALL have parameter DIV_W, default 20: width of half-period values and the divider counter.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable-sample count required (10 ms at 50 MHz).
REQ-004 SHALL have port clk_50MHz  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port reset_button  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port keys  in  NUM_KEYS: raw asynchronous key inputs; active-high.
REQ-007 SHALL have port oct_up  in  1: octave-up mode; halves the effective half-period.
REQ-008 SHALL have port cfg_we  in  1: table write strobe.
REQ-009 SHALL have port cfg_addr  in  clog2(NUM_KEYS): table entry index; out-of-range writes are ignored.
REQ-010 SHALL have port cfg_data  in  DIV_W: half-period in clk_50MHz cycles; 0 = silent.
REQ-011 SHALL have port bz_out  out  1: square-wave buzzer drive.
REQ-012 SHALL have port active  out  1: high while state is LOAD or RUN.
REQ-013 SHALL have port key_idx  out  clog2(NUM_KEYS): registered index of the selected key.

Function
REQ-014 Each key SHALL pass a 2-flop synchroniser, then a per-key debouncer; key_db[i] SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronised samples; any differing sample SHALL clear that key's counter.
REQ-015 Selection SHALL be registered: sel_valid = OR(key_db); key_idx = lowest asserted index (lowest index wins); key_idx SHALL hold its last value when sel_valid=0.
REQ-016 Table SHALL hold NUM_KEYS entries of DIV_W bits; a write in cycle t SHALL be visible to reads from cycle t+1.
REQ-017 Effective half-period SHALL be H = T[key_idx] when oct_up=0, and H = max(T[key_idx]>>1, 1) when oct_up=1 and T[key_idx]!=0.
REQ-018 FSM SHALL have states IDLE, LOAD, RUN.
REQ-019 IDLE: bz_out=0, counter=0; go to LOAD when sel_valid=1 and T[key_idx]!=0.
REQ-020 LOAD (one cycle): latch H and key_idx into h_reg and cur_key, clear counter, bz_out=0, go to RUN.
REQ-021 RUN: counter increments each cycle; when counter==h_reg-1, bz_out SHALL toggle, counter SHALL clear, and h_reg SHALL reload H from the current table entry and oct_up.
REQ-022 Table writes and oct_up changes SHALL affect pitch only at the next toggle boundary, never mid-half-period.
REQ-023 In RUN, if sel_valid=0 or T[key_idx]==0, the FSM SHALL go to IDLE and bz_out SHALL be 0 from the next cycle.
REQ-024 In RUN, if key_idx!=cur_key, the FSM SHALL go to LOAD (bz_out low, restart with new pitch).
REQ-025 Frequency SHALL be 50e6/(2*h_reg) Hz; h_reg=1 SHALL give a 25 MHz toggle with no error.
REQ-026 Simultaneous key change and toggle boundary: key change SHALL take priority (go to LOAD).
REQ-027 Total RTL SHALL remain combinational-loop-free; bz_out SHALL be driven directly from a flop.

Reset
REQ-028 While reset_button=1: bz_out=0, active=0, key_idx=0, state=IDLE, all debounce counters and key_db=0, synchronisers=0, table entries=0.
REQ-029 Reset asserted mid-note SHALL force bz_out=0 asynchronously; after release, no tone SHALL sound until the table is rewritten.

Verification (NUM_KEYS=4, DIV_W=8, DEBOUNCE_CYCLES=4)
REQ-030 Write T[1]=3, hold keys=4'b0010 -> active rises; bz_out period 6 cycles (3 high, 3 low); key_idx=1.
REQ-031 keys=4'b0110 with T[1]=3, T[2]=5 -> key 1 wins; release key 1 -> LOAD, then period 10, key_idx=2.
REQ-032 Key 1 bounces high 3 cycles, low 1, repeated -> key_db never asserts, bz_out stays 0, active=0.
REQ-033 Playing T[0]=6, set oct_up=1 mid-half-period -> current half-period completes at 6, subsequent half-periods 3.
REQ-034 Playing key 3, write T[3]=0 -> IDLE at next cycle, bz_out=0; write T[3]=1 -> bz_out toggles every cycle.
REQ-035 Assert reset_button mid-note -> bz_out=0 immediately; after release, holding the key produces no tone (table cleared).
